// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU mode codes, arbiter FSM encodings and mode helpers
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m == ALU_ADD) || (m == ALU_SUB) || (m == ALU_AND) || (m == ALU_OR);
  endfunction

  function automatic logic mode_has_carry(input logic [2:0] m);
    return (m == ALU_ADD) || (m == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signals of the arbiter
interface alu_arbiter_if;

  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_mode;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_mode;
  logic [7:0] req1_a;
  logic [7:0] req1_b;

  logic       rsp0_valid;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       rsp_err;

  logic       alu_enable;
  logic [2:0] alu_mode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       alu_carry;

  modport master (
    output req0_valid, req0_mode, req0_a, req0_b,
    output req1_valid, req1_mode, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_carry, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  alu_enable, alu_mode, alu_a, alu_b,
    output alu_out, alu_zero, alu_carry
  );

  modport slave (
    input  req0_valid, req0_mode, req0_a, req0_b,
    input  req1_valid, req1_mode, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_carry, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output alu_enable, alu_mode, alu_a, alu_b,
    input  alu_out, alu_zero, alu_carry
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant; last_grant only moves on an accepted grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered external ALU between two requesters, one op in flight
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  arb_state_t state;
  logic [1:0] grant;
  logic       accept;
  logic       owner;
  logic       owner_ready;
  logic [2:0] sel_mode;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic [2:0] mode_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       alu_enable_q;
  logic [1:0] rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_zero_q;
  logic       rsp_carry_q;
  logic       rsp_err_q;

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign accept      = (state == ST_IDLE) && (grant != 2'b00);
  assign sel_mode    = grant[1] ? bus.req1_mode : bus.req0_mode;
  assign sel_a       = grant[1] ? bus.req1_a    : bus.req0_a;
  assign sel_b       = grant[1] ? bus.req1_b    : bus.req0_b;
  assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = (state == ST_IDLE) && grant[0];
  assign bus.req1_ready = (state == ST_IDLE) && grant[1];
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_enable = alu_enable_q;
  assign bus.alu_mode   = mode_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      mode_q       <= 3'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      alu_enable_q <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= 8'd0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      alu_enable_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner  <= grant[1];
            mode_q <= sel_mode;
            a_q    <= sel_a;
            b_q    <= sel_b;
            if (mode_legal(sel_mode)) begin
              alu_enable_q <= 1'b1;
              rsp_err_q    <= 1'b0;
              state        <= ST_ISSUE;
            end else begin
              // Illegal code skips the ALU entirely and answers with an error
              rsp_valid_q <= grant;
              rsp_data_q  <= 8'd0;
              rsp_zero_q  <= 1'b0;
              rsp_carry_q <= 1'b0;
              rsp_err_q   <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          rsp_data_q  <= bus.alu_out;
          rsp_zero_q  <= bus.alu_zero;
          rsp_carry_q <= mode_has_carry(mode_q) ? bus.alu_carry : 1'b0;
          rsp_valid_q <= owner ? 2'b10 : 2'b01;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_ready) begin
            rsp_valid_q <= 2'b00;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Clock and reset: single clock clk, rising edge; reset rst is synchronous and active-high.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  out  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_mode  in  3  ALU operation code (ALU_ADD/ALU_SUB/ALU_AND/ALU_OR).
REQ-007 reqN_a, reqN_b  in  8 each  operands.
REQ-008 rspN_valid  out  1  result for requester N is held on rsp_*.
REQ-009 rspN_ready  in  1  requester N consumes its result.
REQ-010 rsp_data  out  8; rsp_zero, rsp_carry, rsp_err  out  1 each  shared result bus.
REQ-011 alu_enable  out  1; alu_mode  out  3; alu_a, alu_b  out  8 each  drive to the shared ALU.
REQ-012 alu_out  in  8; alu_zero, alu_carry  in  1 each  ALU registered outputs.

Function
REQ-013 FSM states: IDLE, ISSUE, CAPTURE, RESP; one operation in flight at a time.
REQ-014 IDLE: reqN_ready is high only for the granted requester; all other readys are low in every other state.
REQ-015 Grant: only one valid -> that one; both valid -> the requester not granted last (round-robin); last_grant resets to 1, so req0 wins first.
REQ-016 Accept (valid&&ready in IDLE): latch owner, mode, a and b; next state ISSUE, or RESP with rsp_err=1 and rsp_data=0 if the mode is not one of the four legal codes.
REQ-017 ISSUE: alu_enable=1 for exactly this cycle with the latched mode and operands; next state CAPTURE.
REQ-018 alu_enable is 0 in every state except ISSUE; alu_mode/alu_a/alu_b hold the latched values at all times.
REQ-019 CAPTURE: register alu_out into rsp_data and alu_zero into rsp_zero; next state RESP.
REQ-020 rsp_carry = alu_carry for ADD/SUB and is forced 0 for AND/OR; the stale ALU carry is never forwarded.
REQ-021 RESP: rspN_valid=1 for the owner only, and rsp_* are held stable until rspN_ready; on the handshake -> IDLE.
REQ-022 Latency: accept in cycle C -> rspN_valid first high in cycle C+3; peak throughput is one operation per 4 cycles.
REQ-023 Backpressure: while RESP waits, no new request is accepted and the ALU is not enabled.
REQ-024 A requester dropping valid before it is accepted is legal and causes no state change.
REQ-025 last_grant updates on accept only.

Reset
REQ-026 While rst=1 at a clock edge: state->IDLE, last_grant->1, all rspN_valid/reqN_ready effects->0, alu_enable->0, rsp_data/rsp_zero/rsp_carry/rsp_err->0, latched mode/operands->0.
REQ-027 Reset mid-operation (ISSUE, CAPTURE or RESP) abandons the operation with no response delivered; the first post-reset request must produce a correct result even though the ALU itself is not reset.

Structure
REQ-028 ALU mode codes stay in the shared parameters include; the arbiter FSM state encodings are added there as well.
REQ-029 The ALU is instantiated outside this block; alu_arbiter contains no arithmetic.
REQ-030 The round-robin grant logic is one natural sub-module, rr_arb2 (2-input, combinational grant plus registered last_grant).

Verification
REQ-031 req0 ADD a=0xF0 b=0x20 accepted in cycle C -> in C+3, rsp0_valid=1, rsp_data=0x10, rsp_carry=1, rsp_zero=0; alu_enable high only in C+1.
REQ-032 req1 SUB 0x05-0x05 -> rsp_data=0x00, zero=1, carry=0; then SUB 0x03-0x05 -> rsp_data=0xFE, carry=1, zero=0.
REQ-033 Both valid continuously after reset, rsp_ready=1 -> grants in order req0, req1, req0, req1; every response is routed to the correct rspN_valid.
REQ-034 ADD 0xFF+0x01 (carry=1), then AND 0x0F&0xF0 -> second response rsp_data=0x00, zero=1, carry=0.
REQ-035 rsp0_ready held low 5 cycles in RESP -> rsp_data is stable, req1_ready=0 and alu_enable=0 throughout; release -> IDLE the next cycle.
REQ-036 rst pulsed during ISSUE -> no rspN_valid is asserted; the next ADD 0x01+0x01 returns 0x02 at C+3; an illegal mode returns rsp_err=1 at C+1 with no alu_enable.
